// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the fabric-side 8N1 UART receiver.
package uart_rx_pkg;

    // Receive FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } rx_state_t;

    // Ticks per bit, mid-bit sample offset within the start bit, data bits per frame
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/rx_sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is always presented
// on head_data while not empty; a push into a full FIFO is accepted only when a
// pop in the same cycle frees the slot.
module rx_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign count   = count_reg;
    // Head reads as zero while empty so the output has a defined reset value
    assign head_data = empty ? '0 : mem[rd_ptr_reg];

    // Storage write; no reset needed on the array itself
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, sticky line-error flags and a
// first-word-fall-through receive FIFO.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV = 54,
    parameter int DEPTH   = 16
) (
    input  logic                     FAB_CCC_GL0,
    input  logic                     FAB_RESET_N,
    input  logic                     RXD,
    output logic [7:0]               RX_DATA,
    output logic                     RX_VALID,
    input  logic                     RX_READY,
    output logic                     FRAME_ERR,
    output logic                     OVERRUN,
    input  logic                     ERR_CLR,
    output logic [$clog2(DEPTH):0]   FIFO_COUNT
);
    logic        clk;
    logic        rst_n;
    assign clk   = FAB_CCC_GL0;
    assign rst_n = FAB_RESET_N;

    logic        sync1_reg;
    logic        rxs;
    logic [15:0] div_cnt_reg;
    logic        tick;
    rx_state_t   state_reg;
    rx_state_t   state_next;
    logic [3:0]  sub_cnt_reg;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  shift_reg;
    logic        push;
    logic        frame_set;
    logic        bit_sample;
    logic        frame_err_reg;
    logic        overrun_reg;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;

    // Two-flop synchroniser for the asynchronous serial line, idling high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            rxs       <= 1'b1;
        end else begin
            sync1_reg <= RXD;
            rxs       <= sync1_reg;
        end
    end

    // Free-running oversample divider
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
        end else if (tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end
    assign tick = (div_cnt_reg == 16'(CLK_DIV - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic; everything advances on oversample ticks only
    always_comb begin
        state_next = state_reg;
        if (tick) begin
            case (state_reg)
                IDLE:    if (!rxs) state_next = START;
                START:   if (sub_cnt_reg == 4'(MID_SAMPLE - 1))
                             state_next = rxs ? IDLE : DATA;
                DATA:    if (sub_cnt_reg == 4'(OVERSAMPLE - 1) &&
                             bit_idx_reg == 3'(DATA_BITS - 1))
                             state_next = STOP;
                STOP:    if (sub_cnt_reg == 4'(OVERSAMPLE - 1))
                             state_next = rxs ? IDLE : WAIT_HI;
                WAIT_HI: if (rxs) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs: data-bit sample strobe, byte push and framing-error event
    always_comb begin
        bit_sample = 1'b0;
        push       = 1'b0;
        frame_set  = 1'b0;
        if (tick && sub_cnt_reg == 4'(OVERSAMPLE - 1)) begin
            if (state_reg == DATA) bit_sample = 1'b1;
            if (state_reg == STOP) begin
                push      = rxs;
                frame_set = !rxs;
            end
        end
    end

    // Sub-tick counter, bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else if (tick) begin
            if (state_next != state_reg) begin
                sub_cnt_reg <= '0;
            end else if (state_reg == START || state_reg == DATA || state_reg == STOP) begin
                sub_cnt_reg <= sub_cnt_reg + 1'b1;
            end
            if (state_reg == START) begin
                bit_idx_reg <= '0;
            end else if (bit_sample) begin
                bit_idx_reg <= bit_idx_reg + 1'b1;
                shift_reg   <= {rxs, shift_reg[7:1]};
            end
        end
    end

    assign pop = RX_READY && !fifo_empty;

    // Sticky error flags; a set event takes priority over a clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (frame_set)            frame_err_reg <= 1'b1;
            else if (ERR_CLR)         frame_err_reg <= 1'b0;
            if (push && fifo_full && !pop) overrun_reg <= 1'b1;
            else if (ERR_CLR)         overrun_reg   <= 1'b0;
        end
    end

    rx_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shift_reg),
        .pop       (pop),
        .head_data (RX_DATA),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (FIFO_COUNT)
    );

    assign RX_VALID  = !fifo_empty;
    assign FRAME_ERR = frame_err_reg;
    assign OVERRUN   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo with CLK_DIV=4 (64-clock bit period), DEPTH=16.
module tb_uart_rx_fifo;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 16;
    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;
    logic [4:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    int dcnt     = 0;

    uart_rx_fifo #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
        .FAB_CCC_GL0 (clk),
        .FAB_RESET_N (rst_n),
        .RXD         (rxd),
        .RX_DATA     (rx_data),
        .RX_VALID    (rx_valid),
        .RX_READY    (rx_ready),
        .FRAME_ERR   (frame_err),
        .OVERRUN     (overrun),
        .ERR_CLR     (err_clr),
        .FIFO_COUNT  (fifo_count)
    );

    always #5 clk = ~clk;

    // Oversample phase reference: counter 0..CLK_DIV-1 from reset release
    always @(posedge clk) begin
        if (!rst_n) dcnt <= 0;
        else        dcnt <= (dcnt == CLK_DIV - 1) ? 0 : dcnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serialise one frame; the stop level is held for stop_len clocks
    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
        rxd = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_clk(BIT_CLK);
        end
        rxd = stop;
        wait_clk(stop_len);
        rxd = 1'b1;
    endtask

    // Check the head byte then accept it with a one-clock ready pulse
    task automatic pop_check(input string tag, input logic [7:0] exp);
        check_val({tag, "_valid"}, 32'(rx_valid), 32'd1);
        check_val({tag, "_data"}, 32'(rx_data), 32'(exp));
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
    endtask

    int lat;
    int m;
    int k;

    initial begin
        rst_n    = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);

        // Reset state
        check_val("rst_valid", 32'(rx_valid), 32'd0);
        check_val("rst_data", 32'(rx_data), 32'h00);
        check_val("rst_frame_err", 32'(frame_err), 32'd0);
        check_val("rst_overrun", 32'(overrun), 32'd0);
        check_val("rst_count", 32'(fifo_count), 32'd0);

        // Single byte, including push latency window (sync + tick jitter + 152 ticks + 1)
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, BIT_CLK);
            begin
                while (lat < 700 && !rx_valid) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check_val("a5_latency_ok", 32'(lat >= 612 && lat <= 615), 32'd1);
        check_val("a5_count", 32'(fifo_count), 32'd1);
        pop_check("a5", 8'hA5);
        check_val("a5_popped_valid", 32'(rx_valid), 32'd0);
        check_val("a5_popped_count", 32'(fifo_count), 32'd0);

        // Glitch rejection
        wait_clk(10);
        rxd = 1'b0;
        wait_clk(24);
        rxd = 1'b1;
        wait_clk(700);
        check_val("glitch_valid", 32'(rx_valid), 32'd0);
        check_val("glitch_frame_err", 32'(frame_err), 32'd0);
        check_val("glitch_overrun", 32'(overrun), 32'd0);

        // Framing error, line held low, then recovery with 0x81
        send_frame(8'h3C, 1'b0, BIT_CLK + 200);
        check_val("ferr_set", 32'(frame_err), 32'd1);
        check_val("ferr_discard_count", 32'(fifo_count), 32'd0);
        wait_clk(20);
        send_frame(8'h81, 1'b1, BIT_CLK);
        check_val("ferr_next_count", 32'(fifo_count), 32'd1);
        check_val("ferr_still_set", 32'(frame_err), 32'd1);
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        check_val("ferr_cleared", 32'(frame_err), 32'd0);
        pop_check("b81", 8'h81);

        // Overrun: 17 bytes into a 16-deep FIFO with no reads
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, BIT_CLK);
            wait_clk(4);
            if (i == 15) begin
                check_val("ovr_full_count", 32'(fifo_count), 32'd16);
                check_val("ovr_not_yet", 32'(overrun), 32'd0);
            end
        end
        check_val("ovr_count", 32'(fifo_count), 32'd16);
        check_val("ovr_flag", 32'(overrun), 32'd1);
        for (int i = 0; i < 16; i++) pop_check($sformatf("ovr_pop%0d", i), 8'(i));
        check_val("ovr_drained", 32'(rx_valid), 32'd0);
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        check_val("ovr_cleared", 32'(overrun), 32'd0);

        // Full FIFO with a pop exactly on the stop-sample tick of 0x55
        for (int i = 0; i < 16; i++) begin
            send_frame(8'h20 + 8'(i), 1'b1, BIT_CLK);
            wait_clk(4);
        end
        check_val("fp_full_count", 32'(fifo_count), 32'd16);
        m = (7 - dcnt) % 4;
        while (m < 2) m += 4;
        k = m + 1;
        fork
            send_frame(8'h55, 1'b1, BIT_CLK);
            begin
                wait_clk(k + 607);
                rx_ready = 1'b1;
                wait_clk(1);
                rx_ready = 1'b0;
            end
        join
        check_val("fp_overrun", 32'(overrun), 32'd0);
        check_val("fp_count", 32'(fifo_count), 32'd16);
        for (int i = 1; i < 16; i++) pop_check($sformatf("fp_pop%0d", i), 8'h20 + 8'(i));
        pop_check("fp_last", 8'h55);
        check_val("fp_drained", 32'(rx_valid), 32'd0);

        // Reset during bit 4 of 0xF0 with one byte already queued
        send_frame(8'h77, 1'b1, BIT_CLK);
        wait_clk(4);
        check_val("pre_rst_count", 32'(fifo_count), 32'd1);
        fork
            send_frame(8'hF0, 1'b1, BIT_CLK);
            begin
                wait_clk(BIT_CLK + 4 * BIT_CLK + BIT_CLK / 2);
                rst_n = 1'b0;
                wait_clk(1);
                rst_n = 1'b1;
                check_val("mrst_valid", 32'(rx_valid), 32'd0);
                check_val("mrst_data", 32'(rx_data), 32'h00);
                check_val("mrst_frame_err", 32'(frame_err), 32'd0);
                check_val("mrst_overrun", 32'(overrun), 32'd0);
                check_val("mrst_count", 32'(fifo_count), 32'd0);
            end
        join
        check_val("mrst_no_push", 32'(rx_valid), 32'd0);
        wait_clk(10);
        send_frame(8'h12, 1'b1, BIT_CLK);
        check_val("post_rst_count", 32'(fifo_count), 32'd1);
        pop_check("b12", 8'h12);
        check_val("post_rst_flags", 32'({frame_err, overrun}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
